i2s_tx_scheduler: RTL and testbench
===================================

Name: i2s_tx_scheduler

Overview:
Frame scheduler and serial-clock generator for the I2S transmit path of the APB I2S peripheral. Sits between the left/right TX FIFOs and the I2S pins. Pops one stereo pair per frame, serialises it in Philips I2S format, and auto-stops when the FIFOs drain or enable drops. Pulses o_done so the register block clears CR.I2S_ENABLE.

Parameters:
DATA_W, 32, sample width per channel; frame = 2*DATA_W slots
DIV_W, 8, width of SCK divider setting

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous reset, active-high
i_enable  in  1  CR.I2S_ENABLE level
i_clk_div  in  DIV_W  SCK half-period minus 1, in i_clk cycles
i_fifol_empty  in  1  left FIFO empty
i_fifor_empty  in  1  right FIFO empty
i_fifol_data  in  DATA_W  left FIFO head word (first-word fall-through)
i_fifor_data  in  DATA_W  right FIFO head word (first-word fall-through)
o_fifol_rd  out  1  left pop, one-cycle pulse
o_fifor_rd  out  1  right pop, one-cycle pulse
o_sck  out  1  I2S serial clock
o_ws  out  1  word select; 0 = left, 1 = right
o_sd  out  1  serial data, MSB first
o_busy  out  1  high while state = ACTIVE
o_done  out  1  one-cycle pulse on every stop
o_underflow  out  1  one-cycle pulse when exactly one FIFO is empty at a fetch point

Behaviour:
- Clock is i_clk; reset is asynchronous, active-high, on i_rst.
- Reset: state IDLE; all outputs 0; shift register, slot counter and divider counter cleared.
- States: IDLE, ACTIVE.
- Fetch check (IDLE with i_enable=1, or each frame boundary in ACTIVE):
  - i_enable=1 and both FIFOs non-empty: pop both the same cycle, load shift register {L,R}.
  - Both FIFOs empty, or i_enable=0 at a boundary: go IDLE, pulse o_done, no pop.
  - Exactly one FIFO empty: go IDLE, pulse o_underflow and o_done, no pop.
- IDLE to ACTIVE:
  - The fetch cycle latches i_clk_div into an internal register; i_clk_div changes while ACTIVE are ignored.
  - On the next cycle o_sd = L[DATA_W-1], o_sck = 0, o_ws = 0, o_busy = 1.
  - Latency from i_enable high (FIFOs non-empty) to pop pulse: 1 cycle.
- SCK generation:
  - Divider counts 0..div; at terminal count it wraps and o_sck toggles.
  - Half-period = div+1 cycles; slot = 2*(div+1) cycles; frame = 2*DATA_W slots.
- Slots:
  - Slot counter 0..2*DATA_W-1 advances on each o_sck falling toggle, updating o_sd/o_ws in that same cycle.
  - Slots 0..DATA_W-1 drive L[DATA_W-1..0]; slots DATA_W..2*DATA_W-1 drive R[DATA_W-1..0].
  - o_ws = 1 for slots DATA_W-1..2*DATA_W-2, else 0: WS leads the MSB by one slot (Philips).
- Frame boundary:
  - The falling toggle that would wrap slot 2*DATA_W-1 to 0 is the fetch point.
  - Continue: pop both, reload, slot 0 starts with no gap.
  - Stop: o_sck held 0, o_ws = 0, o_sd = 0, o_busy = 0, same cycle as o_done.
- i_enable dropping mid-frame: current frame completes, then stop at the boundary.
- Popping never occurs with the corresponding empty flag set.
- o_rd pulses never coincide with o_done.
- Reset mid-frame: immediate return to the reset state; no further pops.

Optional Feature:
Macro I2S_SCHED_MONO_EN.
- Defined: adds input i_mono (1 bit).
  - When i_mono=1, only the left FIFO is checked and popped; the right slots replay the left sample.
  - i_fifor_empty is ignored; o_fifor_rd stays 0; o_underflow never fires.
  - i_mono is sampled only at fetch points.
- Undefined: no i_mono port; stereo behaviour only.

Test Plan:
- Reset -> all outputs 0, o_busy=0; holding i_rst high with i_enable=1 and FIFOs full -> no pops, o_sck static.
- div=1; one pair L=32'hA5A50001, R=32'h5A5A8000; i_enable=1 -> both rd pulse 1 cycle later; o_sck period 4 cycles; o_ws rises after 31 falling edges; sd bit stream matches {L,R} MSB-first; o_done at cycle 256 after start; o_sck then static 0.
- div=0; four pairs preloaded -> four contiguous 64-slot frames (128 cycles each), pops exactly at boundaries, no gap, one o_done after the 4th frame.
- Right FIFO empties after frame 1 while left still holds data -> o_underflow and o_done at the boundary, no pop, left data retained.
- i_enable cleared at slot 10 with FIFOs non-empty -> frame completes all 64 slots, no pop, o_done at the boundary.
- i_enable=1 with both FIFOs empty -> o_done the next cycle, no o_sck toggle, no pops.

Source files
------------

// File: rtl/i2s_tx_scheduler.sv
// rtl/i2s_tx_scheduler.sv - I2S TX frame scheduler and SCK generator; optional mono mode under I2S_SCHED_MONO_EN
module i2s_tx_scheduler #(
    parameter int DATA_W = 32,
    parameter int DIV_W  = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_enable,
    input  logic [DIV_W-1:0]  i_clk_div,
    input  logic              i_fifol_empty,
    input  logic              i_fifor_empty,
    input  logic [DATA_W-1:0] i_fifol_data,
    input  logic [DATA_W-1:0] i_fifor_data,
`ifdef I2S_SCHED_MONO_EN
    input  logic              i_mono,
`endif
    output logic              o_fifol_rd,
    output logic              o_fifor_rd,
    output logic              o_sck,
    output logic              o_ws,
    output logic              o_sd,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_underflow
);
    localparam int SLOT_W = $clog2(2 * DATA_W);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(2 * DATA_W - 1);
    localparam logic [SLOT_W-1:0] WS_FIRST  = SLOT_W'(DATA_W - 1);
    localparam logic [SLOT_W-1:0] WS_LAST   = SLOT_W'(2 * DATA_W - 2);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [DIV_W-1:0]    cnt_q, cnt_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [SLOT_W-1:0]   slot_inc;
    logic [2*DATA_W-1:0] shreg_q, shreg_d;
    logic                sck_d, ws_d, sd_d, busy_d, done_d, uf_d, rdl_d, rdr_d;
    logic                mono, pair_ok, one_empty, fetch;

`ifdef I2S_SCHED_MONO_EN
    assign mono = i_mono;
`else
    assign mono = 1'b0;
`endif

    // In mono mode the right FIFO is irrelevant, so it can neither block a fetch nor underflow
    assign pair_ok   = !i_fifol_empty && (mono || !i_fifor_empty);
    assign one_empty = !mono && (i_fifol_empty != i_fifor_empty);
    assign slot_inc  = slot_q + 1'b1;

    // Next-state: divider/SCK toggling, slot advance on falling SCK, and the shared fetch decision
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        slot_d  = slot_q;
        shreg_d = shreg_q;
        sck_d   = o_sck;
        ws_d    = o_ws;
        sd_d    = o_sd;
        busy_d  = o_busy;
        done_d  = 1'b0;
        uf_d    = 1'b0;
        rdl_d   = 1'b0;
        rdr_d   = 1'b0;
        fetch   = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_enable) begin
                    div_d = i_clk_div;
                    fetch = 1'b1;
                end
            end
            ACTIVE: begin
                if (cnt_q == div_q) begin
                    cnt_d = '0;
                    sck_d = !o_sck;
                    if (o_sck) begin
                        // Falling toggle: either the frame boundary or the next slot
                        if (slot_q == LAST_SLOT) begin
                            fetch = 1'b1;
                        end else begin
                            slot_d  = slot_inc;
                            shreg_d = {shreg_q[2*DATA_W-2:0], 1'b0};
                            sd_d    = shreg_q[2*DATA_W-2];
                            ws_d    = (slot_inc >= WS_FIRST) && (slot_inc <= WS_LAST);
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (fetch) begin
            cnt_d  = '0;
            slot_d = '0;
            sck_d  = 1'b0;
            ws_d   = 1'b0;
            if (i_enable && pair_ok) begin
                state_d = ACTIVE;
                busy_d  = 1'b1;
                rdl_d   = 1'b1;
                rdr_d   = !mono;
                shreg_d = mono ? {i_fifol_data, i_fifol_data} : {i_fifol_data, i_fifor_data};
                sd_d    = i_fifol_data[DATA_W-1];
            end else begin
                state_d = IDLE;
                busy_d  = 1'b0;
                sd_d    = 1'b0;
                done_d  = 1'b1;
                uf_d    = i_enable && one_empty;
            end
        end
    end

    // State and registered outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            div_q       <= '0;
            cnt_q       <= '0;
            slot_q      <= '0;
            shreg_q     <= '0;
            o_sck       <= 1'b0;
            o_ws        <= 1'b0;
            o_sd        <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_underflow <= 1'b0;
            o_fifol_rd  <= 1'b0;
            o_fifor_rd  <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            slot_q      <= slot_d;
            shreg_q     <= shreg_d;
            o_sck       <= sck_d;
            o_ws        <= ws_d;
            o_sd        <= sd_d;
            o_busy      <= busy_d;
            o_done      <= done_d;
            o_underflow <= uf_d;
            o_fifol_rd  <= rdl_d;
            o_fifor_rd  <= rdr_d;
        end
    end
endmodule

// File: tb/tb_i2s_tx_scheduler.sv
// tb/tb_i2s_tx_scheduler.sv - randomized model-based bench for i2s_tx_scheduler
module tb_i2s_tx_scheduler;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [7:0]  div = 8'd0;
    logic        fl_empty, fr_empty;
    logic [31:0] fl_data, fr_data;
    logic        o_fifol_rd, o_fifor_rd, o_sck, o_ws, o_sd, o_busy, o_done, o_underflow;

    logic [31:0] ql[$];
    logic [31:0] qr[$];
    int          errors = 0;
    int          checks = 0;

    bit          m_active = 1'b0;
    int          m_t = 0;
    int          m_div = 0;
    logic [63:0] m_word = '0;
    logic [7:0]  exp_vec = '0;
    bit          prev_rdl = 1'b0;
    bit          prev_rdr = 1'b0;

    i2s_tx_scheduler #(.DATA_W(32), .DIV_W(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_enable(en), .i_clk_div(div),
        .i_fifol_empty(fl_empty), .i_fifor_empty(fr_empty),
        .i_fifol_data(fl_data), .i_fifor_data(fr_data),
        .o_fifol_rd(o_fifol_rd), .o_fifor_rd(o_fifor_rd),
        .o_sck(o_sck), .o_ws(o_ws), .o_sd(o_sd), .o_busy(o_busy),
        .o_done(o_done), .o_underflow(o_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected outputs from frame position: slot = t / slot_len, SCK high in the second half of a slot
    function automatic logic [7:0] expect_vec(input bit rd, input bit dn, input bit uf);
        int half, slot, ph;
        logic sck, ws, sd;
        if (!m_active) return {6'b0, dn, uf};
        half = m_div + 1;
        slot = m_t / (2 * half);
        ph   = m_t % (2 * half);
        sck  = (ph >= half);
        sd   = m_word[63 - slot];
        ws   = (slot >= 31) && (slot <= 62);
        return {sck, ws, sd, 1'b1, rd, rd, 1'b0, 1'b0};
    endfunction

    task automatic model_update();
        bit fetch, rd, dn, uf;
        fetch = 1'b0; rd = 1'b0; dn = 1'b0; uf = 1'b0;
        if (rst) begin
            m_active = 1'b0;
            exp_vec  = '0;
            return;
        end
        if (m_active) begin
            m_t++;
            if (m_t == 128 * (m_div + 1)) fetch = 1'b1;
        end else if (en) begin
            fetch = 1'b1;
            m_div = int'(div);
        end
        if (fetch) begin
            if (en && ql.size() > 0 && qr.size() > 0) begin
                m_active = 1'b1;
                m_t      = 0;
                m_word   = {ql[0], qr[0]};
                rd       = 1'b1;
            end else begin
                m_active = 1'b0;
                dn       = 1'b1;
                uf       = en && ((ql.size() == 0) != (qr.size() == 0));
            end
        end
        exp_vec = expect_vec(rd, dn, uf);
    endtask

    // Compare the current cycle, then retire pops requested in the previous cycle
    task automatic sync();
        logic [31:0] dummy;
        @(negedge clk);
        chk("outs", {56'b0, o_sck, o_ws, o_sd, o_busy, o_fifol_rd, o_fifor_rd, o_done, o_underflow},
            {56'b0, exp_vec});
        if (prev_rdl && ql.size() > 0) dummy = ql.pop_front();
        if (prev_rdr && qr.size() > 0) dummy = qr.pop_front();
        prev_rdl = o_fifol_rd;
        prev_rdr = o_fifor_rd;
        // Register block clears the enable bit when it sees done
        if (exp_vec[1]) en = 1'b0;
    endtask

    task automatic commit();
        fl_empty = (ql.size() == 0);
        fr_empty = (qr.size() == 0);
        fl_data  = (ql.size() > 0) ? ql[0] : 32'h0;
        fr_data  = (qr.size() > 0) ? qr[0] : 32'h0;
        model_update();
    endtask

    task automatic step();
        sync();
        commit();
    endtask

    task automatic load(input int nl, input int nr);
        for (int i = 0; i < nl; i++) ql.push_back($urandom);
        for (int i = 0; i < nr; i++) qr.push_back($urandom);
    endtask

    initial begin
        int nl, nr, len, drop;
        // Reset held with enable and full FIFOs: nothing moves
        rst = 1'b1; en = 1'b1; div = 8'd1;
        load(4, 4);
        commit();
        repeat (8) step();
        chk("rst_no_pop", 64'(ql.size() + qr.size()), 64'd8);
        sync(); rst = 1'b0; en = 1'b0; ql.delete(); qr.delete(); commit();
        repeat (3) step();

        // Single known pair, div=1
        sync(); div = 8'd1; ql.push_back(32'hA5A50001); qr.push_back(32'h5A5A8000); en = 1'b1; commit();
        repeat (280) step();

        // Four contiguous frames, div=0
        sync(); div = 8'd0; load(4, 4); en = 1'b1; commit();
        repeat (4 * 128 + 20) step();
        chk("frames_drained", 64'(ql.size() + qr.size()), 64'd0);

        // Right FIFO runs dry after one frame
        sync(); div = 8'd2; load(2, 1); en = 1'b1; commit();
        repeat (2 * 128 * 3 + 20) step();
        chk("uf_left_kept", 64'(ql.size()), 64'd1);
        chk("uf_right_empty", 64'(qr.size()), 64'd0);
        sync(); ql.delete(); en = 1'b0; commit();

        // Enable dropped at slot 10: frame completes, no further pop
        sync(); div = 8'd0; load(3, 3); en = 1'b1; commit();
        repeat (20) step();
        sync(); en = 1'b0; commit();
        repeat (128 + 20) step();
        chk("drop_left_kept", 64'(ql.size()), 64'd2);
        chk("drop_right_kept", 64'(qr.size()), 64'd2);
        sync(); ql.delete(); qr.delete(); commit();

        // Enable with both FIFOs empty
        sync(); en = 1'b1; commit();
        repeat (10) step();

        // Randomized rounds, including divider changes while active
        for (int r = 0; r < 6; r++) begin
            nl = $urandom_range(0, 3);
            case ($urandom_range(0, 3))
                0:       nr = nl + 1;
                1:       nr = (nl > 0) ? nl - 1 : 0;
                default: nr = nl;
            endcase
            sync(); div = 8'($urandom_range(0, 3)); load(nl, nr); en = 1'b1; commit();
            len  = (nl + 1) * 128 * 4 + 20;
            drop = $urandom_range(0, len);
            for (int i = 0; i < len; i++) begin
                sync();
                if (i == drop) en = 1'b0;
                if ($urandom_range(0, 63) == 0) div = 8'($urandom_range(0, 3));
                commit();
            end
            sync(); en = 1'b0; ql.delete(); qr.delete(); commit();
            repeat (4) step();
        end

        // Reset mid-frame: immediate return to idle, no further pops
        sync(); div = 8'd0; load(2, 2); en = 1'b1; commit();
        repeat (50) step();
        sync(); rst = 1'b1; commit();
        repeat (10) step();
        chk("rst_mid_left", 64'(ql.size()), 64'd1);
        chk("rst_mid_right", 64'(qr.size()), 64'd1);
        sync(); rst = 1'b0; en = 1'b0; commit();
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
